midi_voice_ctrl: RTL and testbench
==================================

MIDI_VOICE_CTRL -- requirements
Module: midi_voice_ctrl

Interface
REQ-001 Parameter: MIDI_CHANNEL, 0, receive channel (0-15) whose channel-voice messages are accepted.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; asynchronous and active-high.
REQ-004 BYTE_IN  input  8  received MIDI byte, qualified by BYTE_VALID.
REQ-005 BYTE_VALID  input  1  one-cycle strobe; BYTE_IN is consumed on each cycle it is high.
REQ-006 NOTE_NUM  output  7  current note number, feeds the oscillator's NOTE_NUM.
REQ-007 VELOCITY  output  7  velocity of the current note.
REQ-008 GATE  output  1  high while a note is held.
REQ-009 PROGRAM  output  7  current program number, feeds the oscillator's PROGRAM.
REQ-010 NOTE_STROBE  output  1  one-cycle pulse on each accepted note-on.

Function
REQ-011 Parser FSM SHALL have states IDLE, DATA1, DATA2; state changes only on cycles with BYTE_VALID=1.
REQ-012 Status bytes 0x80-0xEF SHALL latch the status and go to DATA1, from any state, abandoning any partial message.
REQ-013 Real-time bytes 0xF8-0xFF SHALL be ignored without changing state or latched status.
REQ-014 System-common bytes 0xF0-0xF7 SHALL clear latched status and go to IDLE; subsequent data bytes are ignored until the next channel status.
REQ-015 Messages whose channel nibble is not MIDI_CHANNEL SHALL be parsed (byte counting kept) but not acted on.
REQ-016 Two-byte messages (0x8n, 0x9n, 0xAn, 0xBn, 0xEn): DATA1 -> DATA2 -> execute; 0xAn, 0xBn, 0xEn are parsed and discarded.
REQ-017 One-byte messages (0xCn, 0xDn): DATA1 -> execute; 0xDn is discarded.
REQ-018 Note-on with velocity >0 SHALL set NOTE_NUM, VELOCITY, GATE=1 and pulse NOTE_STROBE, registered on the cycle after the final data byte.
REQ-019 Note-off (0x8n), or note-on with velocity 0, SHALL clear GATE only if its note equals NOTE_NUM; NOTE_NUM and VELOCITY are held.
REQ-020 Program change SHALL load PROGRAM with the data byte on the cycle after that byte.
REQ-021 Data byte (bit7=0) received in IDLE with no latched status SHALL be ignored.
REQ-022 A new note-on while GATE=1 SHALL replace the note (last-note priority) and retrigger NOTE_STROBE.

Reset
REQ-023 RST=1 SHALL immediately force state IDLE, latched status cleared, NOTE_NUM=0, VELOCITY=0, GATE=0, PROGRAM=0, NOTE_STROBE=0, including mid-message.

Configuration
REQ-024 Macro MIDI_RUNNING_STATUS_EN defined: after a message executes, state returns to DATA1 with status kept, so further data bytes form new messages.
REQ-025 Macro not defined: after execution, latched status is cleared and state returns to IDLE; data bytes without a fresh status are ignored.

Structure
REQ-026 Package vsynth_midi_pkg SHALL hold status-nibble constants (NOTE_OFF=8, NOTE_ON=9, PROG_CHG=0xC, etc.), the FSM state type, and the data-bytes-per-status lookup function.
REQ-027 One sub-module, midi_status_classify (combinational: byte -> is_status, is_realtime, is_syscommon, nibble, channel, data-byte count), is natural; the rest stays in midi_voice_ctrl.

Verification
REQ-028 0x90,0x3C,0x64 -> NOTE_NUM=60, VELOCITY=100, GATE=1, one NOTE_STROBE pulse, one cycle after 0x64.
REQ-029 Then 0x80,0x3D,0x40 -> GATE stays 1; then 0x80,0x3C,0x40 -> GATE=0, NOTE_NUM stays 60.
REQ-030 0xC0,0x02 -> PROGRAM=2; 0xC3,0x05 with MIDI_CHANNEL=0 -> PROGRAM stays 2.
REQ-031 0x90,0x40,0xF8,0x50 -> note 64 velocity 80 accepted despite interleaved real-time byte.
REQ-032 With MIDI_RUNNING_STATUS_EN: 0x90,0x30,0x10,0x32,0x00 -> note 48 on, then note 50 vel 0 leaves GATE=1; without the macro, 0x32,0x00 are ignored.
REQ-033 RST asserted between 0x90 and 0x3C, then 0x3C,0x64 -> all outputs 0, data bytes ignored, GATE stays 0.

Source files
------------

// File: rtl/vsynth_midi_pkg.sv
// MIDI voice controller shared definitions: status nibbles,
// parser state type and the data-bytes-per-status lookup.
package vsynth_midi_pkg;

  localparam logic [3:0] NOTE_OFF   = 4'h8;
  localparam logic [3:0] NOTE_ON    = 4'h9;
  localparam logic [3:0] POLY_AT    = 4'hA;
  localparam logic [3:0] CTRL_CHG   = 4'hB;
  localparam logic [3:0] PROG_CHG   = 4'hC;
  localparam logic [3:0] CHAN_AT    = 4'hD;
  localparam logic [3:0] PITCH_BEND = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2
  } midi_state_t;

  function automatic logic [1:0] data_bytes(
    input logic [3:0] nib
  );
    logic [1:0] n;
    case (nib)
      NOTE_OFF, NOTE_ON, POLY_AT,
      CTRL_CHG, PITCH_BEND: n = 2'd2;
      PROG_CHG, CHAN_AT:    n = 2'd1;
      default:              n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/midi_status_classify.sv
// Combinational MIDI byte classifier.
// Ports: byte_in -> is_status/is_realtime/is_syscommon, nibble, channel, data_cnt.
module midi_status_classify
  import vsynth_midi_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_status,
  output logic       is_realtime,
  output logic       is_syscommon,
  output logic [3:0] nibble,
  output logic [3:0] channel,
  output logic [1:0] data_cnt
);

  assign is_status    = byte_in[7] && (byte_in[7:4] != 4'hF);
  assign is_realtime  = (byte_in[7:3] == 5'b11111);
  assign is_syscommon = (byte_in[7:3] == 5'b11110);
  assign nibble       = byte_in[7:4];
  assign channel      = byte_in[3:0];
  assign data_cnt     = data_bytes(byte_in[7:4]);

endmodule

// File: rtl/midi_voice_ctrl.sv
// MIDI channel-voice parser driving one monophonic voice.
// Ports: CLK, RST (async high), BYTE_IN/BYTE_VALID in;
// NOTE_NUM, VELOCITY, GATE, PROGRAM, NOTE_STROBE out.
// Option: MIDI_RUNNING_STATUS_EN keeps status after a message.
module midi_voice_ctrl
  import vsynth_midi_pkg::*;
#(
  parameter int MIDI_CHANNEL = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  output logic [6:0] NOTE_NUM,
  output logic [6:0] VELOCITY,
  output logic       GATE,
  output logic [6:0] PROGRAM,
  output logic       NOTE_STROBE
);

  localparam logic [3:0] CH = 4'(MIDI_CHANNEL);

  logic       is_st;
  logic       is_rt;
  logic       is_sc;
  logic [3:0] in_nib;
  logic [3:0] in_ch;
  logic [1:0] in_cnt;

  midi_status_classify u_cls (
    .byte_in      (BYTE_IN),
    .is_status    (is_st),
    .is_realtime  (is_rt),
    .is_syscommon (is_sc),
    .nibble       (in_nib),
    .channel      (in_ch),
    .data_cnt     (in_cnt)
  );

  midi_state_t state_q;
  midi_state_t state_d;

  // Latched status: nibble, channel match, data byte count.
  logic [3:0] nib_q;
  logic       ch_ok_q;
  logic [1:0] cnt_q;
  logic [6:0] d1_q;

  logic latch;
  logic clear;
  logic take_d1;
  logic exec;
  logic done_clr;
  midi_state_t done_st;

`ifdef MIDI_RUNNING_STATUS_EN
  assign done_st  = DATA1;
  assign done_clr = 1'b0;
`else
  assign done_st  = IDLE;
  assign done_clr = 1'b1;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    clear   = 1'b0;
    take_d1 = 1'b0;
    exec    = 1'b0;
    if (BYTE_VALID) begin
      unique case (1'b1)
        is_rt: begin
        end
        is_sc: begin
          state_d = IDLE;
          clear   = 1'b1;
        end
        is_st: begin
          state_d = DATA1;
          latch   = 1'b1;
        end
        default: begin
          case (state_q)
            DATA1: begin
              if (cnt_q == 2'd2) begin
                state_d = DATA2;
                take_d1 = 1'b1;
              end else begin
                exec    = 1'b1;
                state_d = done_st;
                clear   = done_clr;
              end
            end
            DATA2: begin
              exec    = 1'b1;
              state_d = done_st;
              clear   = done_clr;
            end
            default: begin
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nib_q       <= 4'd0;
      ch_ok_q     <= 1'b0;
      cnt_q       <= 2'd0;
      d1_q        <= 7'd0;
      NOTE_NUM    <= 7'd0;
      VELOCITY    <= 7'd0;
      GATE        <= 1'b0;
      PROGRAM     <= 7'd0;
      NOTE_STROBE <= 1'b0;
    end else begin
      NOTE_STROBE <= 1'b0;
      if (latch) begin
        nib_q   <= in_nib;
        ch_ok_q <= (in_ch == CH);
        cnt_q   <= in_cnt;
      end else if (clear) begin
        nib_q   <= 4'd0;
        ch_ok_q <= 1'b0;
        cnt_q   <= 2'd0;
      end
      if (take_d1) d1_q <= BYTE_IN[6:0];
      if (exec && ch_ok_q) begin
        case (nib_q)
          NOTE_ON: begin
            if (BYTE_IN[6:0] != 7'd0) begin
              NOTE_NUM    <= d1_q;
              VELOCITY    <= BYTE_IN[6:0];
              GATE        <= 1'b1;
              NOTE_STROBE <= 1'b1;
            end else if (d1_q == NOTE_NUM) begin
              GATE <= 1'b0;
            end
          end
          NOTE_OFF: begin
            if (d1_q == NOTE_NUM) GATE <= 1'b0;
          end
          PROG_CHG: PROGRAM <= BYTE_IN[6:0];
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Directed self-checking bench for midi_voice_ctrl.
// Expected values hand-derived from the MIDI parsing rules.
module tb_midi_voice_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] BYTE_IN = 8'd0;
  logic       BYTE_VALID = 1'b0;
  logic [6:0] NOTE_NUM;
  logic [6:0] VELOCITY;
  logic       GATE;
  logic [6:0] PROGRAM;
  logic       NOTE_STROBE;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  midi_voice_ctrl #(.MIDI_CHANNEL(0)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .BYTE_IN     (BYTE_IN),
    .BYTE_VALID  (BYTE_VALID),
    .NOTE_NUM    (NOTE_NUM),
    .VELOCITY    (VELOCITY),
    .GATE        (GATE),
    .PROGRAM     (PROGRAM),
    .NOTE_STROBE (NOTE_STROBE)
  );

  // Drives one byte for one cycle; returns at the next negedge,
  // when the effect of that byte is visible.
  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    @(negedge CLK);
    BYTE_VALID = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    total++; if (NOTE_NUM !== 7'd0) begin bad++; $display("FAIL rst_note got=%0d want=0", NOTE_NUM); end
    total++; if (VELOCITY !== 7'd0) begin bad++; $display("FAIL rst_vel got=%0d want=0", VELOCITY); end
    total++; if (GATE !== 1'b0) begin bad++; $display("FAIL rst_gate got=%b want=0", GATE); end
    total++; if (PROGRAM !== 7'd0) begin bad++; $display("FAIL rst_prog got=%0d want=0", PROGRAM); end
    total++; if (NOTE_STROBE !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b want=0", NOTE_STROBE); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_note_on;
    send(8'h90);
    send(8'h3C);
    total++; if (GATE !== 1'b0) begin bad++; $display("FAIL on_early_gate got=%b want=0", GATE); end
    total++; if (NOTE_STROBE !== 1'b0) begin bad++; $display("FAIL on_early_strobe got=%b want=0", NOTE_STROBE); end
    send(8'h64);
    total++; if (NOTE_NUM !== 7'd60) begin bad++; $display("FAIL on_note got=%0d want=60", NOTE_NUM); end
    total++; if (VELOCITY !== 7'd100) begin bad++; $display("FAIL on_vel got=%0d want=100", VELOCITY); end
    total++; if (GATE !== 1'b1) begin bad++; $display("FAIL on_gate got=%b want=1", GATE); end
    total++; if (NOTE_STROBE !== 1'b1) begin bad++; $display("FAIL on_strobe got=%b want=1", NOTE_STROBE); end
    @(negedge CLK);
    total++; if (NOTE_STROBE !== 1'b0) begin bad++; $display("FAIL on_strobe_end got=%b want=0", NOTE_STROBE); end
  endtask

  task automatic test_note_off;
    send(8'h80); send(8'h3D); send(8'h40);
    total++; if (GATE !== 1'b1) begin bad++; $display("FAIL off_other_gate got=%b want=1", GATE); end
    send(8'h80); send(8'h3C); send(8'h40);
    total++; if (GATE !== 1'b0) begin bad++; $display("FAIL off_gate got=%b want=0", GATE); end
    total++; if (NOTE_NUM !== 7'd60) begin bad++; $display("FAIL off_note got=%0d want=60", NOTE_NUM); end
    total++; if (VELOCITY !== 7'd100) begin bad++; $display("FAIL off_vel got=%0d want=100", VELOCITY); end
  endtask

  task automatic test_program;
    send(8'hC0); send(8'h02);
    total++; if (PROGRAM !== 7'd2) begin bad++; $display("FAIL prog got=%0d want=2", PROGRAM); end
    send(8'hC3); send(8'h05);
    total++; if (PROGRAM !== 7'd2) begin bad++; $display("FAIL prog_other_ch got=%0d want=2", PROGRAM); end
  endtask

  task automatic test_realtime;
    send(8'h90); send(8'h40); send(8'hF8);
    total++; if (NOTE_NUM !== 7'd60) begin bad++; $display("FAIL rt_mid_note got=%0d want=60", NOTE_NUM); end
    send(8'h50);
    total++; if (NOTE_NUM !== 7'd64) begin bad++; $display("FAIL rt_note got=%0d want=64", NOTE_NUM); end
    total++; if (VELOCITY !== 7'd80) begin bad++; $display("FAIL rt_vel got=%0d want=80", VELOCITY); end
    total++; if (GATE !== 1'b1) begin bad++; $display("FAIL rt_gate got=%b want=1", GATE); end
    total++; if (NOTE_STROBE !== 1'b1) begin bad++; $display("FAIL rt_strobe got=%b want=1", NOTE_STROBE); end
  endtask

  task automatic test_running_status;
    logic [6:0] exp_note;
    logic [6:0] exp_vel;
    send(8'h90); send(8'h30); send(8'h10);
    total++; if (NOTE_NUM !== 7'd48) begin bad++; $display("FAIL rs_note got=%0d want=48", NOTE_NUM); end
    send(8'h32); send(8'h00);
    total++; if (GATE !== 1'b1) begin bad++; $display("FAIL rs_gate got=%b want=1", GATE); end
    total++; if (NOTE_NUM !== 7'd48) begin bad++; $display("FAIL rs_note_hold got=%0d want=48", NOTE_NUM); end
    send(8'h34); send(8'h20);
`ifdef MIDI_RUNNING_STATUS_EN
    exp_note = 7'd52;
    exp_vel  = 7'd32;
`else
    exp_note = 7'd48;
    exp_vel  = 7'd16;
`endif
    total++; if (NOTE_NUM !== exp_note) begin bad++; $display("FAIL rs_next_note got=%0d want=%0d", NOTE_NUM, exp_note); end
    total++; if (VELOCITY !== exp_vel) begin bad++; $display("FAIL rs_next_vel got=%0d want=%0d", VELOCITY, exp_vel); end
  endtask

  task automatic test_syscommon;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h90); send(8'hF0); send(8'h3E);
    send(8'h70);
    total++; if (NOTE_NUM !== 7'd60) begin bad++; $display("FAIL sc_note got=%0d want=60", NOTE_NUM); end
    total++; if (NOTE_STROBE !== 1'b0) begin bad++; $display("FAIL sc_strobe got=%b want=0", NOTE_STROBE); end
  endtask

  task automatic test_abandon;
    send(8'h90); send(8'h3E);
    send(8'hC0); send(8'h07);
    total++; if (PROGRAM !== 7'd7) begin bad++; $display("FAIL ab_prog got=%0d want=7", PROGRAM); end
    total++; if (NOTE_NUM !== 7'd60) begin bad++; $display("FAIL ab_note got=%0d want=60", NOTE_NUM); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [6];
    seq = '{8'h90, 8'h41, 8'h22, 8'h90, 8'h42, 8'h23};
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (i == 3) begin
        total++; if (NOTE_NUM !== 7'h41) begin bad++; $display("FAIL b2b_first got=%0h want=41", NOTE_NUM); end
        total++; if (NOTE_STROBE !== 1'b1) begin bad++; $display("FAIL b2b_strobe1 got=%b want=1", NOTE_STROBE); end
      end
      BYTE_IN = seq[i];
      BYTE_VALID = 1'b1;
    end
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    total++; if (NOTE_NUM !== 7'h42) begin bad++; $display("FAIL b2b_note got=%0h want=42", NOTE_NUM); end
    total++; if (VELOCITY !== 7'h23) begin bad++; $display("FAIL b2b_vel got=%0h want=23", VELOCITY); end
    total++; if (NOTE_STROBE !== 1'b1) begin bad++; $display("FAIL b2b_strobe2 got=%b want=1", NOTE_STROBE); end
  endtask

  task automatic test_reset_mid;
    send(8'h90);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    send(8'h3C); send(8'h64);
    total++; if (NOTE_NUM !== 7'd0) begin bad++; $display("FAIL rm_note got=%0d want=0", NOTE_NUM); end
    total++; if (VELOCITY !== 7'd0) begin bad++; $display("FAIL rm_vel got=%0d want=0", VELOCITY); end
    total++; if (GATE !== 1'b0) begin bad++; $display("FAIL rm_gate got=%b want=0", GATE); end
    total++; if (PROGRAM !== 7'd0) begin bad++; $display("FAIL rm_prog got=%0d want=0", PROGRAM); end
    total++; if (NOTE_STROBE !== 1'b0) begin bad++; $display("FAIL rm_strobe got=%b want=0", NOTE_STROBE); end
  endtask

  initial begin
    test_reset;
    test_note_on;
    test_note_off;
    test_program;
    test_realtime;
    test_running_status;
    test_syscommon;
    test_abandon;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
